fpro_bus_arbiter: RTL and testbench

//  Two-master arbiter for the FPro MMIO bus in front of mmio_sys.

---
 rtl/fpro_arb_pkg.sv | 25 ++
 rtl/fpro_bus_arbiter_if.sv | 46 ++++
 rtl/rr_arb2.sv | 26 ++
 rtl/fpro_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpro_arb_pkg.sv
// Shared types for the two-master FPro MMIO bus arbiter.
package fpro_arb_pkg;

  localparam int N_MST = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

  typedef struct packed {
    logic     valid;
    mst_idx_t idx;
  } lock_t;

  // A held lock narrows eligibility to its owner; otherwise both masters compete.
  function automatic logic [N_MST-1:0] elig_mask(input lock_t l);
    if (!l.valid) return 2'b11;
    return l.idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fpro_bus_arbiter_if.sv
// Bundle of both master request/ack channels and the downstream FPro MMIO bus.
interface fpro_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);

  logic              m0_req;
  logic              m0_wr;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr_data;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rd_data;

  logic              m1_req;
  logic              m1_wr;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr_data;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rd_data;

  logic              fp_mmio_cs;
  logic              fp_rd;
  logic              fp_wr;
  logic [ADDR_W-1:0] fp_addr;
  logic [DATA_W-1:0] fp_wr_data;
  logic [DATA_W-1:0] fp_rd_data;

  modport slave (
    input  m0_req, m0_wr, m0_lock, m0_addr, m0_wr_data,
    input  m1_req, m1_wr, m1_lock, m1_addr, m1_wr_data,
    input  fp_rd_data,
    output m0_ack, m0_rd_data, m1_ack, m1_rd_data,
    output fp_mmio_cs, fp_rd, fp_wr, fp_addr, fp_wr_data
  );

  modport master (
    output m0_req, m0_wr, m0_lock, m0_addr, m0_wr_data,
    output m1_req, m1_wr, m1_lock, m1_addr, m1_wr_data,
    output fp_rd_data,
    input  m0_ack, m0_rd_data, m1_ack, m1_rd_data,
    input  fp_mmio_cs, fp_rd, fp_wr, fp_addr, fp_wr_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the master that did not win last time goes.
module rr_arb2
  import fpro_arb_pkg::*;
(
  input  logic [N_MST-1:0] i_req,
  input  logic [N_MST-1:0] i_elig,
  input  mst_idx_t         i_last_gnt,
  output logic             o_gnt_valid,
  output mst_idx_t         o_gnt_idx
);

  logic [N_MST-1:0] w_cand;

  always_comb begin
    w_cand      = i_req & i_elig;
    o_gnt_valid = |w_cand;
    o_gnt_idx   = 1'b0;
    case (w_cand)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = ~i_last_gnt;
      default: o_gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Two-master FPro MMIO arbiter: IDLE -> ISSUE -> ACK per single-beat transaction, round-robin with bus lock.
// Define FPRO_ARB_CNT_EN to add per-master grant counters (m0_gnt_cnt, m1_gnt_cnt) and cnt_clr.
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
`ifdef FPRO_ARB_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fpro_bus_arbiter_if.slave     bus
`ifdef FPRO_ARB_CNT_EN
  , input  logic                cnt_clr
  , output logic [CNT_W-1:0]    m0_gnt_cnt
  , output logic [CNT_W-1:0]    m1_gnt_cnt
`endif
);

  arb_state_t        r_state;
  mst_idx_t          r_gnt_idx;
  mst_idx_t          r_last_gnt;
  logic              r_lock_req;
  lock_t             r_lock_own;

  logic              r_fp_cs;
  logic              r_fp_rd;
  logic              r_fp_wr;
  logic [ADDR_W-1:0] r_fp_addr;
  logic [DATA_W-1:0] r_fp_wr_data;

  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rd_data;
  logic [DATA_W-1:0] r_m1_rd_data;

  logic [N_MST-1:0]  w_req;
  logic              w_gnt_valid;
  mst_idx_t          w_gnt_idx;
  logic              w_sel_wr;
  logic              w_sel_lock;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_req = {bus.m1_req, bus.m0_req};

  rr_arb2 u_rr_arb2 (
    .i_req       (w_req),
    .i_elig      (elig_mask(r_lock_own)),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  always_comb begin
    w_sel_wr    = bus.m0_wr;
    w_sel_lock  = bus.m0_lock;
    w_sel_addr  = bus.m0_addr;
    w_sel_wdata = bus.m0_wr_data;
    if (w_gnt_idx) begin
      w_sel_wr    = bus.m1_wr;
      w_sel_lock  = bus.m1_lock;
      w_sel_addr  = bus.m1_addr;
      w_sel_wdata = bus.m1_wr_data;
    end
  end

  // The fp_* registers double as the registered request copy: loaded on grant, cleared after ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_gnt_idx    <= 1'b0;
      r_last_gnt   <= 1'b1;
      r_lock_req   <= 1'b0;
      r_lock_own   <= '0;
      r_fp_cs      <= 1'b0;
      r_fp_rd      <= 1'b0;
      r_fp_wr      <= 1'b0;
      r_fp_addr    <= '0;
      r_fp_wr_data <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rd_data <= '0;
      r_m1_rd_data <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_gnt_idx    <= w_gnt_idx;
            r_lock_req   <= w_sel_lock;
            r_fp_cs      <= 1'b1;
            r_fp_wr      <= w_sel_wr;
            r_fp_rd      <= ~w_sel_wr;
            r_fp_addr    <= w_sel_addr;
            r_fp_wr_data <= w_sel_wdata;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_fp_cs      <= 1'b0;
          r_fp_rd      <= 1'b0;
          r_fp_wr      <= 1'b0;
          r_fp_addr    <= '0;
          r_fp_wr_data <= '0;
          if (r_fp_rd) begin
            if (r_gnt_idx) r_m1_rd_data <= bus.fp_rd_data;
            else           r_m0_rd_data <= bus.fp_rd_data;
          end
          if (r_gnt_idx) r_m1_ack <= 1'b1;
          else           r_m0_ack <= 1'b1;
          r_state <= ACK;
        end
        ACK: begin
          r_last_gnt <= r_gnt_idx;
          r_lock_own <= '{valid: r_lock_req, idx: r_gnt_idx};
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fp_mmio_cs = r_fp_cs;
  assign bus.fp_rd      = r_fp_rd;
  assign bus.fp_wr      = r_fp_wr;
  assign bus.fp_addr    = r_fp_addr;
  assign bus.fp_wr_data = r_fp_wr_data;
  assign bus.m0_ack     = r_m0_ack;
  assign bus.m1_ack     = r_m1_ack;
  assign bus.m0_rd_data = r_m0_rd_data;
  assign bus.m1_rd_data = r_m1_rd_data;

`ifdef FPRO_ARB_CNT_EN
  logic [CNT_W-1:0] r_m0_cnt;
  logic [CNT_W-1:0] r_m1_cnt;

  // Clear wins over a same-cycle increment; counts wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m0_cnt <= '0;
      r_m1_cnt <= '0;
    end else if (cnt_clr) begin
      r_m0_cnt <= '0;
      r_m1_cnt <= '0;
    end else if (r_state == ACK) begin
      if (r_gnt_idx) r_m1_cnt <= r_m1_cnt + CNT_W'(1);
      else           r_m0_cnt <= r_m0_cnt + CNT_W'(1);
    end
  end

  assign m0_gnt_cnt = r_m0_cnt;
  assign m1_gnt_cnt = r_m1_cnt;
`endif

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Counter checks are compiled in when FPRO_ARB_CNT_EN is defined.
module tb_fpro_bus_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpro_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef FPRO_ARB_CNT_EN
  localparam int CW = 4;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] m0_gnt_cnt;
  logic [CW-1:0] m1_gnt_cnt;
  logic [CW-1:0] mc [2];
  bit            clr_now = 1'b0;
  bit            clr_on_ack = 1'b0;

  fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .cnt_clr(cnt_clr), .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt)
  );
`else
  fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
`endif

  typedef struct packed {
    logic          wr;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  txn_t cur [2];
  bit   act [2];

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            exp_strobe, exp_ack, free_cyc;
  bit            exp_m;
  txn_t          exp_t;
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] pend_rd;
  bit            last_gnt, lk_v, lk_i;
  bit            in_rst, rnd_mode, force_rd;
  logic [DW-1:0] force_val;
  bit            count_lock, seen_m1;
  int            n_m0_before_m1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic lock, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.wr = wr; t.lock = lock; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), AW'($urandom()), $urandom());
  endfunction

  task automatic model_reset();
    exp_strobe = -10;
    exp_ack    = -10;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
    last_gnt   = 1'b1;
    lk_v       = 1'b0;
    lk_i       = 1'b0;
`ifdef FPRO_ARB_CNT_EN
    mc[0] = '0;
    mc[1] = '0;
`endif
  endtask

  task automatic check_outputs();
    bit s;
    s = (cyc == exp_strobe);
    if (cyc == exp_ack && !exp_t.wr) exp_rd[exp_m] = pend_rd;
    check_val("fp_mmio_cs", 64'(bus.fp_mmio_cs), 64'(s));
    check_val("fp_rd",      64'(bus.fp_rd),      64'(s && !exp_t.wr));
    check_val("fp_wr",      64'(bus.fp_wr),      64'(s && exp_t.wr));
    check_val("fp_addr",    64'(bus.fp_addr),    s ? 64'(exp_t.addr) : 64'd0);
    check_val("fp_wr_data", 64'(bus.fp_wr_data), s ? 64'(exp_t.data) : 64'd0);
    check_val("m0_ack",     64'(bus.m0_ack),     64'(cyc == exp_ack && exp_m == 1'b0));
    check_val("m1_ack",     64'(bus.m1_ack),     64'(cyc == exp_ack && exp_m == 1'b1));
    check_val("m0_rd_data", 64'(bus.m0_rd_data), 64'(exp_rd[0]));
    check_val("m1_rd_data", 64'(bus.m1_rd_data), 64'(exp_rd[1]));
`ifdef FPRO_ARB_CNT_EN
    check_val("m0_gnt_cnt", 64'(m0_gnt_cnt), 64'(mc[0]));
    check_val("m1_gnt_cnt", 64'(m1_gnt_cnt), 64'(mc[1]));
`endif
    if (count_lock) begin
      if (bus.m1_ack) seen_m1 = 1'b1;
      if (bus.m0_ack && !seen_m1) n_m0_before_m1++;
    end
  endtask

  task automatic drive_masters();
    if (cyc == exp_ack) act[exp_m] = 1'b0;
    if (!act[0]) begin
      if (rnd_mode && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
      if (q0.size() != 0) begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
    end
    if (!act[1]) begin
      if (rnd_mode && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
      if (q1.size() != 0) begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
    end
    bus.m0_req = act[0]; bus.m0_wr = cur[0].wr; bus.m0_lock = cur[0].lock;
    bus.m0_addr = cur[0].addr; bus.m0_wr_data = cur[0].data;
    bus.m1_req = act[1]; bus.m1_wr = cur[1].wr; bus.m1_lock = cur[1].lock;
    bus.m1_addr = cur[1].addr; bus.m1_wr_data = cur[1].data;
    bus.fp_rd_data = force_rd ? force_val : $urandom();
    if (cyc == exp_strobe) pend_rd = bus.fp_rd_data;
`ifdef FPRO_ARB_CNT_EN
    cnt_clr = clr_now || (clr_on_ack && cyc == exp_ack);
    if (cnt_clr) begin
      mc[0] = '0;
      mc[1] = '0;
    end else if (cyc == exp_ack) begin
      mc[exp_m] = mc[exp_m] + 1'b1;
    end
`endif
  endtask

  // Arbitration rules at transaction level: a free bus grants one eligible requester,
  // ties go to the master that did not win last, a held lock admits only its owner.
  task automatic model_arbitrate();
    bit e0, e1, w;
    if (in_rst || cyc < free_cyc) return;
    e0 = act[0] && (!lk_v || lk_i == 1'b0);
    e1 = act[1] && (!lk_v || lk_i == 1'b1);
    if (!(e0 || e1)) return;
    w = (e0 && e1) ? ~last_gnt : e1;
    exp_m      = w;
    exp_t      = cur[w];
    exp_strobe = cyc + 1;
    exp_ack    = cyc + 2;
    free_cyc   = cyc + 3;
    last_gnt   = w;
    lk_v       = cur[w].lock;
    lk_i       = w;
  endtask

  task automatic step(input bit release_rst);
    @(negedge clk);
    cyc++;
    check_outputs();
    if (release_rst) begin
      reset_n  = 1'b1;
      in_rst   = 1'b0;
      free_cyc = cyc;
    end
    drive_masters();
    model_arbitrate();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] || cyc <= exp_ack) && n < 400) begin
      if (lk_v && !act[lk_i] && ((lk_i == 1'b0) ? q0.size() == 0 : q1.size() == 0)) begin
        if (lk_i == 1'b0) q0.push_back(mk(1'b1, 1'b0, AW'(21'h1FFFF0), 32'h0));
        else              q1.push_back(mk(1'b1, 1'b0, AW'(21'h1FFFF1), 32'h0));
      end
      step(1'b0);
      n++;
    end
    if (n >= 400) check_val("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    act[0] = 1'b0; act[1] = 1'b0;
    cur[0] = '0;   cur[1] = '0;
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_wr_data = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_wr_data = '0;
    bus.fp_rd_data = '0;
    in_rst = 1'b1; rnd_mode = 1'b0; force_rd = 1'b0; force_val = '0; pend_rd = '0;
    count_lock = 1'b0; seen_m1 = 1'b0; n_m0_before_m1 = 0;
    exp_t = '0; exp_m = 1'b0; free_cyc = 0;
    model_reset();

    // Reset held, then released
    repeat (3) step(1'b0);
    step(1'b1);

    // m0 write
    q0.push_back(mk(1'b1, 1'b0, AW'(21'h00010), 32'hDEAD_BEEF));
    drain();

    // m1 read with fixed bus read data
    force_rd = 1'b1; force_val = 32'h1234_5678;
    q1.push_back(mk(1'b0, 1'b0, AW'(21'h00020), 32'h0));
    drain();
    force_rd = 1'b0;
    check_val("m1_rd_hold", 64'(bus.m1_rd_data), 64'h1234_5678);

    // Saturation: both masters keep requesting
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'(i % 2), 1'b0, AW'(21'h100 + i), 32'hA000_0000 + 32'(i)));
      q1.push_back(mk(1'((i + 1) % 2), 1'b0, AW'(21'h200 + i), 32'hB000_0000 + 32'(i)));
    end
    drain();

    // Lock: m0 holds the bus for three locked transactions plus the unlocking one
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, (i < 3), AW'(21'h300 + i), 32'hC000_0000 + 32'(i)));
    q1.push_back(mk(1'b1, 1'b0, AW'(21'h400), 32'hD000_0000));
    q1.push_back(mk(1'b0, 1'b0, AW'(21'h401), 32'hD000_0001));
    count_lock = 1'b1;
    drain();
    count_lock = 1'b0;
    check_val("lock_m0_acks_before_m1", 64'(n_m0_before_m1), 64'd4);

    // Random traffic
    rnd_mode = 1'b1;
    repeat (1500) step(1'b0);
    rnd_mode = 1'b0;
    drain();

`ifdef FPRO_ARB_CNT_EN
    clr_now = 1'b1;
    step(1'b0);
    clr_now = 1'b0;
    for (int i = 0; i < 17; i++) q0.push_back(mk(1'b1, 1'b0, AW'(21'h500 + i), 32'(i)));
    drain();
    check_val("cnt_after_17", 64'(m0_gnt_cnt), 64'd1);
    q0.push_back(mk(1'b1, 1'b0, AW'(21'h600), 32'h0));
    clr_on_ack = 1'b1;
    drain();
    clr_on_ack = 1'b0;
    check_val("cnt_after_clr", 64'(m0_gnt_cnt), 64'd0);
`endif

    // Asynchronous reset during an m1 ISSUE cycle
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b1, 1'b0, AW'(21'h700 + i), 32'hE000_0000 + 32'(i)));
      q1.push_back(mk(1'b1, 1'b0, AW'(21'h800 + i), 32'hF000_0000 + 32'(i)));
    end
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (!(exp_strobe == cyc + 1 && exp_m == 1'b1) && n < 100);
    if (n >= 100) check_val("reset_wait_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    in_rst  = 1'b1;
    #1;
    model_reset();
    check_outputs();
    step(1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
